// File: rtl/imm_gen_if.sv
// Handshake bundle between fetch, the immediate generator and execute.
interface imm_gen_if #(
    parameter int REG_WIDTH = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instruction;
    logic                 out_valid;
    logic                 out_ready;
    logic [REG_WIDTH-1:0] imm;
    logic [2:0]           fmt;
    logic [31:0]          instr_out;

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, imm, fmt, instr_out
    );

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, imm, fmt, instr_out
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational RV32I/RV64I immediate
// decode feeding a 2-entry (main + skid) valid/ready buffer with flush.
module imm_gen_pipe #(
    parameter int REG_WIDTH = 64
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    imm_gen_if.slave  bus
);
    if (REG_WIDTH != 32 && REG_WIDTH != 64) begin : g_bad_width
        $error("imm_gen_pipe: REG_WIDTH must be 32 or 64");
    end

    localparam bit IS64 = (REG_WIDTH == 64);

    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_I    = 3'd1;
    localparam logic [2:0] F_S    = 3'd2;
    localparam logic [2:0] F_B    = 3'd3;
    localparam logic [2:0] F_U    = 3'd4;
    localparam logic [2:0] F_J    = 3'd5;
    localparam logic [2:0] F_Z    = 3'd6;
    localparam logic [2:0] F_SH   = 3'd7;

    typedef struct packed {
        logic [REG_WIDTH-1:0] imm;
        logic [2:0]           fmt;
        logic [31:0]          instr;
    } entry_t;

    logic [31:0] ins;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        is_shift;
    entry_t      dec;
    entry_t      main_q;
    entry_t      skid_q;
    logic        main_vld;
    logic        skid_vld;
    logic        accept;
    logic        advance;

    assign ins      = bus.instruction;
    assign op       = ins[6:0];
    assign f3       = ins[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Immediate decode; unknown opcodes still flow with imm 0 / fmt NONE
    always_comb begin
        dec.imm   = '0;
        dec.fmt   = F_NONE;
        dec.instr = ins;
        case (op)
            7'b0000011, 7'b1100111: begin
                dec.imm = REG_WIDTH'($signed(ins[31:20]));
                dec.fmt = F_I;
            end
            7'b0010011: begin
                if (is_shift) begin
                    // funct6/funct7 (e.g. the srai bit) must not leak into shamt
                    dec.imm = IS64 ? REG_WIDTH'(ins[25:20]) : REG_WIDTH'(ins[24:20]);
                    dec.fmt = F_SH;
                end else begin
                    dec.imm = REG_WIDTH'($signed(ins[31:20]));
                    dec.fmt = F_I;
                end
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on RV64
                if (IS64) begin
                    if (is_shift) begin
                        dec.imm = REG_WIDTH'(ins[24:20]);
                        dec.fmt = F_SH;
                    end else begin
                        dec.imm = REG_WIDTH'($signed(ins[31:20]));
                        dec.fmt = F_I;
                    end
                end
            end
            7'b0100011: begin
                dec.imm = REG_WIDTH'($signed({ins[31:25], ins[11:7]}));
                dec.fmt = F_S;
            end
            7'b1100011: begin
                dec.imm = REG_WIDTH'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                dec.fmt = F_B;
            end
            7'b1101111: begin
                dec.imm = REG_WIDTH'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                dec.fmt = F_J;
            end
            7'b0110111, 7'b0010111: begin
                dec.imm = REG_WIDTH'($signed({ins[31:12], 12'b0}));
                dec.fmt = F_U;
            end
            7'b1110011: begin
                if (f3[2]) begin
                    dec.imm = REG_WIDTH'(ins[19:15]);
                    dec.fmt = F_Z;
                end
            end
            default: ;
        endcase
    end

    // in_ready comes straight from the skid flag, so out_ready never
    // reaches it combinationally
    assign accept  = bus.in_valid && !skid_vld && !flush;
    assign advance = !main_vld || bus.out_ready;

    // Main/skid buffer; data fields only load alongside a valid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (advance) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= accept;
                if (accept) main_q <= dec;
            end
        end else if (accept) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
        end
    end

    assign bus.in_ready  = !skid_vld;
    assign bus.out_valid = main_vld;
    assign bus.imm       = main_q.imm;
    assign bus.fmt       = main_q.fmt;
    assign bus.instr_out = main_q.instr;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized + directed bench for imm_gen_pipe at both widths, driven in
// lockstep and checked against a queue-based reference of the buffer.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    imm_gen_if #(.REG_WIDTH(64)) b64 ();
    imm_gen_if #(.REG_WIDTH(32)) b32 ();

    imm_gen_pipe #(.REG_WIDTH(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));
    imm_gen_pipe #(.REG_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));

    int checks   = 0;
    int failures = 0;
    logic [31:0] q[$];   // instructions held by the block, oldest first

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint sext(input longint v, input int bits);
        longint half;
        half = longint'(1) <<< (bits - 1);
        return (v >= half) ? v - (half <<< 1) : v;
    endfunction

    // Reference decode from the instruction-set field layouts
    function automatic void ref_dec(input logic [31:0] ins, input int w,
                                    output logic [63:0] imm, output logic [2:0] fmt);
        longint v;
        logic [6:0] op;
        logic [2:0] f3;
        bit sh;
        op = ins[6:0];
        f3 = ins[14:12];
        sh = (f3 == 3'd1) || (f3 == 3'd5);
        v = 0;
        fmt = 3'd0;
        if (op == 7'h03 || op == 7'h67 || ((op == 7'h13 || (op == 7'h1B && w == 64)) && !sh)) begin
            v = sext(longint'(ins[31:20]), 12); fmt = 3'd1;
        end else if (op == 7'h13 && sh) begin
            v = (w == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]); fmt = 3'd7;
        end else if (op == 7'h1B && w == 64 && sh) begin
            v = longint'(ins[24:20]); fmt = 3'd7;
        end else if (op == 7'h23) begin
            v = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); fmt = 3'd2;
        end else if (op == 7'h63) begin
            v = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                     longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            fmt = 3'd3;
        end else if (op == 7'h6F) begin
            v = sext(longint'(ins[31]) * (longint'(1) <<< 20) + longint'(ins[19:12]) * 4096 +
                     longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            fmt = 3'd5;
        end else if (op == 7'h37 || op == 7'h17) begin
            v = sext(longint'(ins[31:12]) * 4096, 32); fmt = 3'd4;
        end else if (op == 7'h73 && f3 >= 3'd4) begin
            v = longint'(ins[19:15]); fmt = 3'd6;
        end
        imm = (w == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        b64.in_valid = iv; b64.instruction = ins; b64.out_ready = ordy;
        b32.in_valid = iv; b32.instruction = ins; b32.out_ready = ordy;
        flush = fl;
    endtask

    // One clock: check outputs against the model, apply inputs, advance model
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        logic [63:0] e;
        logic [2:0] f;
        bit acc, pop;
        drive(iv, ins, ordy, fl);
        chk("out_valid64", b64.out_valid, q.size() > 0);
        chk("in_ready64",  b64.in_ready,  q.size() < 2);
        chk("out_valid32", b32.out_valid, q.size() > 0);
        chk("in_ready32",  b32.in_ready,  q.size() < 2);
        if (q.size() > 0) begin
            ref_dec(q[0], 64, e, f);
            chk("imm64", b64.imm, e);
            chk("fmt64", b64.fmt, f);
            chk("instr_out64", b64.instr_out, q[0]);
            ref_dec(q[0], 32, e, f);
            chk("imm32", b32.imm, e);
            chk("fmt32", b32.fmt, f);
            chk("instr_out32", b32.instr_out, q[0]);
        end
        acc = iv && (q.size() < 2) && !fl;
        pop = (q.size() > 0) && ordy;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc) q.push_back(ins);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [63:0] e64;
        logic [31:0] e32;
        logic [2:0]  f64;
        logic [2:0]  f32;
    } dir_t;

    dir_t dirs[9];
    logic [6:0] ops[12];

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        dirs[0] = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 3'd1};
        dirs[1] = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd3, 3'd3};
        dirs[2] = '{32'h03F09093, 64'd63, 32'd31, 3'd7, 3'd7};
        dirs[3] = '{32'h43F0D093, 64'd63, 32'd31, 3'd7, 3'd7};
        dirs[4] = '{32'h01F09093, 64'd31, 32'd31, 3'd7, 3'd7};
        dirs[5] = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4, 3'd4};
        dirs[6] = '{32'h3002D073, 64'd5, 32'd5, 3'd6, 3'd6};
        dirs[7] = '{32'h0000000F, 64'd0, 32'd0, 3'd0, 3'd0};
        dirs[8] = '{32'h0010009B, 64'd1, 32'd0, 3'd1, 3'd0};
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h0F, 7'h33};

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_out_valid", b64.out_valid, 1'b0);
        chk("rst_in_ready",  b64.in_ready,  1'b1);
        chk("rst_imm",       b64.imm,       64'd0);
        chk("rst_fmt",       b64.fmt,       3'd0);
        chk("rst_instr_out", b64.instr_out, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed decode, streaming with out_ready high
        foreach (dirs[i]) begin
            cycle(1'b1, dirs[i].ins, 1'b1, 1'b0);
            chk("dir_valid", b64.out_valid, 1'b1);
            chk("dir_imm64", b64.imm, dirs[i].e64);
            chk("dir_fmt64", b64.fmt, dirs[i].f64);
            chk("dir_imm32", b32.imm, dirs[i].e32);
            chk("dir_fmt32", b32.fmt, dirs[i].f32);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: A in main, B in skid, C held upstream
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 1'b0, 1'b0);
        chk("bp_in_ready_low", b64.in_ready, 1'b0);
        cycle(1'b1, 32'h00300093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 1'b0, 1'b0);
        chk("bp_main_a", b64.instr_out, 32'h00100093);
        cycle(1'b1, 32'h00300093, 1'b1, 1'b0);
        chk("bp_main_b", b64.instr_out, 32'h00200093);
        chk("bp_in_ready_up", b64.in_ready, 1'b1);
        cycle(1'b1, 32'h00300093, 1'b1, 1'b0);
        chk("bp_main_c", b64.instr_out, 32'h00300093);
        chk("bp_c_valid", b64.out_valid, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with both entries full and an input on the flush cycle
        cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00600093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00700093, 1'b0, 1'b1);
        chk("flush_out_valid", b64.out_valid, 1'b0);
        chk("flush_in_ready",  b64.in_ready,  1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a stall
        cycle(1'b1, 32'h00800093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00900093, 1'b0, 1'b0);
        drive(1'b1, 32'h00A00093, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", b64.out_valid, 1'b0);
        chk("arst_in_ready",  b64.in_ready,  1'b1);
        chk("arst_imm",       b64.imm,       64'd0);
        chk("arst_instr_out", b64.instr_out, 32'd0);
        chk("arst_in_ready32", b32.in_ready, 1'b1);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_valid", b64.out_valid, 1'b0);
        rst = 1'b0;
        cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        chk("arst_addi_valid", b64.out_valid, 1'b1);
        chk("arst_addi_imm",   b64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic
        repeat (600) begin
            r = $urandom();
            ins = {r[31:7], ops[$urandom_range(0, 11)]};
            cycle($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
        end
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, flow-controlled immediate generator for the decode stage of the five-stage pipeline. It decodes every RV32I/RV64I immediate format, including shift amounts, CSR zimm and OP-IMM-32, and produces a sign- or zero-extended `REG_WIDTH` immediate with a format tag. A 2-entry skid buffer with valid/ready handshakes on both sides decouples fetch from execute stalls. A synchronous flush drops in-flight entries on branch redirect.

## Interface
- `REG_WIDTH`, 64: datapath width. Legal values are 32 and 64; any other value is an elaboration error.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous kill of all buffered entries.
- `in_valid` input 1: `instruction` is valid.
- `in_ready` output 1: block accepts the input this cycle.
- `instruction` input 32: raw instruction word.
- `out_valid` output 1: `imm`, `fmt` and `instr_out` are valid.
- `out_ready` input 1: consumer accepts the output this cycle.
- `imm` output `REG_WIDTH`: extended immediate.
- `fmt` output 3: format tag. 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shift amount).
- `instr_out` output 32: instruction passed through, aligned with `imm`.

## Operation
- Decode is combinational on `instruction`; the result is captured into the buffer.
- `ins` = `instruction`; `sx(x)` = sign-extend `x` to `REG_WIDTH`; `zx(x)` = zero-extend.
- I-format:
  - Opcodes 0000011, 1100111, and 0010011 with funct3 ∉ {001,101}: `imm = sx(ins[31:20])`, fmt I.
  - Opcode 0011011 (OP-IMM-32, only when `REG_WIDTH`=64), same funct3 rule: `imm = sx(ins[31:20])`, fmt I.
- SH (shifts):
  - Opcode 0010011 with funct3 ∈ {001,101}: `imm = zx(ins[25:20])` if `REG_WIDTH`=64, else `zx(ins[24:20])`; fmt SH.
  - Opcode 0011011 with funct3 ∈ {001,101}: `imm = zx(ins[24:20])`, fmt SH.
  - Funct6/funct7 bits never reach `imm`.
- S (0100011): `imm = sx({ins[31:25], ins[11:7]})`.
- B (1100011): `imm = sx({ins[31], ins[7], ins[30:25], ins[11:8], 0})`.
- J (1101111): `imm = sx({ins[31], ins[19:12], ins[20], ins[30:21], 0})`.
- U (0110111, 0010111): `imm = sx({ins[31:12], 12'b0})`. With `REG_WIDTH`=32 this is the 32-bit value unchanged.
- Z (1110011 with funct3[2]=1): `imm = zx(ins[19:15])`.
- Everything else, including 0011011 when `REG_WIDTH`=32, fence and the ecall/ebreak/CSR-register forms: `imm = 0`, fmt NONE. The entry still flows through.
- Buffer: one main register driving the outputs, plus one skid register.
  - Accept: `in_valid && in_ready && !flush`.
  - Main advance when `!out_valid || out_ready`:
    - If the skid is full, main takes the skid entry and the skid empties.
    - Otherwise main takes the accepted input, or becomes invalid if nothing was accepted.
  - Skid fill: an accepted input goes to the skid when main holds (`out_valid && !out_ready`).
  - `in_ready = !skid_valid`, taken from the register. There is no combinational path from `out_ready` to `in_ready`.
  - Order is strictly FIFO. No entry is lost or duplicated.
- Flush:
  - Next edge: `out_valid = 0`, `skid_valid = 0`.
  - An input presented in the flush cycle is dropped, even if `in_ready` = 1.
  - An output handshake in the flush cycle still counts as consumed.
- Data registers load only on a valid load, so data is stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, cleared at the next edge after deassert): `out_valid` 0, `in_ready` 1, `imm` 0, `fmt` 0, `instr_out` 0, skid empty.
- Latency: 1 cycle from input handshake to `out_valid` when the buffer is empty.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- Backpressure: `in_ready` falls one cycle after the skid fills and rises one cycle after the skid drains.
- Reset mid-stall: all entries discarded and `in_ready` = 1 immediately on assertion.
- Flush together with a full skid: both entries killed, `in_ready` = 1 on the next cycle.

## Test plan
- `REG_WIDTH`=64:
  - 0xFFF00093 (addi) gives imm 0xFFFFFFFFFFFFFFFF, fmt 1, one cycle later.
  - 0xFE000EE3 (beq -4) gives imm 0xFFFFFFFFFFFFFFFC, fmt 3.
- Shifts:
  - 0x03F09093 (slli 63) gives imm 63, fmt 7.
  - 0x43F0D093 (srai 63) gives imm 63, not 0x43F.
  - With `REG_WIDTH`=32, 0x01F09093 gives imm 31.
- Upper and CSR immediates:
  - 0x800000B7 (lui) gives 0xFFFFFFFF80000000 at width 64 and 0x80000000 at width 32.
  - 0x3002D073 (csrrwi zimm 5) gives imm 5, fmt 6.
  - 0x0000000F gives imm 0, fmt 0.
- Backpressure: hold `out_ready`=0, then send A, B, C back-to-back.
  - A sits in main and B in the skid; `in_ready` is 0 from the cycle after B is accepted, and C is held upstream.
  - Release `out_ready`: A, B, C emerge on consecutive cycles.
- Flush with both entries full and `in_valid`=1 on the flush cycle: next cycle `out_valid`=0 and `in_ready`=1, and the input presented in the flush cycle never appears at the output.
- Assert `rst` asynchronously mid-stream: outputs go immediately to 0 and `in_valid` stimulus is ignored until release; afterwards a fresh addi emerges with 1-cycle latency.
